// File: rtl/asic_gpio_pkg.sv
// asic_gpio_pkg: register map and data width shared by the GPIO side controller
package asic_gpio_pkg;
  localparam int REG_DW = 32;
  localparam logic [3:0] GPIO_OUT      = 4'd0;
  localparam logic [3:0] GPIO_OE       = 4'd1;
  localparam logic [3:0] GPIO_IE       = 4'd2;
  localparam logic [3:0] GPIO_IN       = 4'd3;
  localparam logic [3:0] GPIO_RISE_EN  = 4'd4;
  localparam logic [3:0] GPIO_FALL_EN  = 4'd5;
  localparam logic [3:0] GPIO_STATUS   = 4'd6;
  localparam logic [3:0] GPIO_TECHSEL  = 4'd7;
  localparam logic [3:0] GPIO_TECHDATA = 4'd8;
endpackage

// File: rtl/asic_gpio_sync.sv
// asic_gpio_sync: multi-flop synchroniser for asynchronous pad inputs
module asic_gpio_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] ff;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/asic_gpio_side.sv
// asic_gpio_side: pad-control registers, input edge capture and irq for one padring side
module asic_gpio_side
  import asic_gpio_pkg::*;
#(
  parameter int N                                  = 9,
  parameter int TECH_CFG_WIDTH                     = 16,
  parameter int SYNC_STAGES                        = 2,
  parameter logic [TECH_CFG_WIDTH-1:0] TECH_CFG_RESET = '0
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        reg_valid,
  input  logic                        reg_write,
  input  logic [3:0]                  reg_addr,
  input  logic [31:0]                 reg_wdata,
  output logic                        reg_done,
  output logic [31:0]                 reg_rdata,
  input  logic [N-1:0]                din,
  output logic [N-1:0]                dout,
  output logic [N-1:0]                oen,
  output logic [N-1:0]                ie,
  output logic [N*TECH_CFG_WIDTH-1:0] tech_cfg,
  output logic                        irq
);
  localparam int TW = TECH_CFG_WIDTH;
  logic [N-1:0] out_r, oe_r, ie_r, rise_en, fall_en, status, s, p, rise, fall, w1c;
  logic [4:0] techsel;
  logic [N*TW-1:0] tech_r;
  logic [REG_DW-1:0] rd_mux, tech_rd;
  logic wr, sel_ok, unused_wdata;
  asic_gpio_sync #(.W(N), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (din),
    .q      (s)
  );
  assign wr           = reg_valid & reg_write;
  assign rise         = s & ~p & ie_r & rise_en;
  assign fall         = ~s & p & ie_r & fall_en;
  assign w1c          = (wr && reg_addr == GPIO_STATUS) ? reg_wdata[N-1:0] : '0;
  assign sel_ok       = int'(techsel) < N;
  assign tech_rd      = sel_ok ? REG_DW'(tech_r[techsel*TW +: TW]) : '0;
  assign unused_wdata = ^reg_wdata;
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      GPIO_OUT:      rd_mux = REG_DW'(out_r);
      GPIO_OE:       rd_mux = REG_DW'(oe_r);
      GPIO_IE:       rd_mux = REG_DW'(ie_r);
      GPIO_IN:       rd_mux = REG_DW'(s & ie_r);
      GPIO_RISE_EN:  rd_mux = REG_DW'(rise_en);
      GPIO_FALL_EN:  rd_mux = REG_DW'(fall_en);
      GPIO_STATUS:   rd_mux = REG_DW'(status);
      GPIO_TECHSEL:  rd_mux = REG_DW'(techsel);
      GPIO_TECHDATA: rd_mux = tech_rd;
      default:       rd_mux = '0;
    endcase
  end
  // Edge sets take priority over a same-cycle write-1-clear
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      out_r     <= '0;
      oe_r      <= '0;
      ie_r      <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      status    <= '0;
      p         <= '0;
      techsel   <= '0;
      tech_r    <= {N{TECH_CFG_RESET}};
      irq       <= 1'b0;
      reg_done  <= 1'b0;
      reg_rdata <= '0;
    end else begin
      p         <= s;
      status    <= (status & ~w1c) | rise | fall;
      irq       <= |status;
      reg_done  <= reg_valid;
      reg_rdata <= (reg_valid && !reg_write) ? rd_mux : '0;
      if (wr)
        case (reg_addr)
          GPIO_OUT:      out_r   <= reg_wdata[N-1:0];
          GPIO_OE:       oe_r    <= reg_wdata[N-1:0];
          GPIO_IE:       ie_r    <= reg_wdata[N-1:0];
          GPIO_RISE_EN:  rise_en <= reg_wdata[N-1:0];
          GPIO_FALL_EN:  fall_en <= reg_wdata[N-1:0];
          GPIO_TECHSEL:  techsel <= reg_wdata[4:0];
          GPIO_TECHDATA: if (sel_ok) tech_r[techsel*TW +: TW] <= reg_wdata[TW-1:0];
          default: ;
        endcase
    end
  assign dout     = out_r;
  assign oen      = ~oe_r;
  assign ie       = ie_r;
  assign tech_cfg = tech_r;
endmodule
